// File: rtl/agg_oq_merge_arbiter_pkg.sv
// Shared types for the output-queue merge arbiter: FSM states, source ids, defaults.
package agg_oq_merge_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB     = 2'd0,
      FWD_BYP = 2'd1,
      FWD_AGG = 2'd2
   } state_t;

   typedef enum logic {
      SRC_BYP = 1'b0,
      SRC_AGG = 1'b1
   } src_t;

   localparam int DEFAULT_WEIGHT    = 1;
   localparam int DEFAULT_CNT_WIDTH = 32;

   function automatic src_t other_src(input src_t s);
      return (s == SRC_BYP) ? SRC_AGG : SRC_BYP;
   endfunction

endpackage

// File: rtl/agg_oq_merge_arbiter_skid_slice.sv
// Two-entry AXI-Stream register slice: outputs come straight from flops, the second
// entry absorbs the beat accepted in the cycle the downstream stalls.
module axis_skid_slice #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             skid_valid_q, skid_valid_d;
   logic [WIDTH-1:0] skid_data_q, skid_data_d;

   assign in_ready  = ~skid_valid_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      if (!out_valid_q || out_ready) begin
         // Output register free: refill from the skid entry first to keep beat order.
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_data_d   = skid_data_q;
            skid_valid_d = 1'b0;
         end else begin
            out_valid_d = in_valid;
            if (in_valid) begin
               out_data_d = in_data;
            end
         end
      end else if (in_valid && !skid_valid_q) begin
         skid_valid_d = 1'b1;
         skid_data_d  = in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
      end else begin
         out_valid_q  <= out_valid_d;
         skid_valid_q <= skid_valid_d;
      end
      out_data_q  <= out_data_d;
      skid_data_q <= skid_data_d;
   end

endmodule

// File: rtl/agg_oq_merge_arbiter.sv
// Per-packet weighted round-robin merge of the bypass and aggregator streams into the
// output-queue stream, with per-source forwarded-packet counters.
module agg_oq_merge_arbiter
   import agg_oq_merge_arbiter_pkg::*;
#(
   parameter int C_M_AXIS_DATA_WIDTH  = 64,
   parameter int C_M_AXIS_TUSER_WIDTH = 128,
   parameter int CREDIT_WIDTH         = 4,
   parameter int CNT_WIDTH            = DEFAULT_CNT_WIDTH
) (
   input  logic                                 axis_aclk,
   input  logic                                 axis_reset,
   input  logic [C_M_AXIS_DATA_WIDTH-1:0]       s_axis_byp_tdata,
   input  logic [C_M_AXIS_DATA_WIDTH/8-1:0]     s_axis_byp_tkeep,
   input  logic [C_M_AXIS_TUSER_WIDTH-1:0]      s_axis_byp_tuser,
   input  logic                                 s_axis_byp_tvalid,
   output logic                                 s_axis_byp_tready,
   input  logic                                 s_axis_byp_tlast,
   input  logic [C_M_AXIS_DATA_WIDTH-1:0]       s_axis_agg_tdata,
   input  logic [C_M_AXIS_DATA_WIDTH/8-1:0]     s_axis_agg_tkeep,
   input  logic [C_M_AXIS_TUSER_WIDTH-1:0]      s_axis_agg_tuser,
   input  logic                                 s_axis_agg_tvalid,
   output logic                                 s_axis_agg_tready,
   input  logic                                 s_axis_agg_tlast,
   output logic [C_M_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
   output logic [C_M_AXIS_DATA_WIDTH/8-1:0]     m_axis_tkeep,
   output logic [C_M_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
   output logic                                 m_axis_tvalid,
   input  logic                                 m_axis_tready,
   output logic                                 m_axis_tlast,
   input  logic [CREDIT_WIDTH-1:0]              cfg_weight_byp,
   input  logic [CREDIT_WIDTH-1:0]              cfg_weight_agg,
   input  logic                                 clear_counters,
   output logic [CNT_WIDTH-1:0]                 pkt_byp_cnt,
   output logic [CNT_WIDTH-1:0]                 pkt_agg_cnt
);

   localparam int DW = C_M_AXIS_DATA_WIDTH;
   localparam int UW = C_M_AXIS_TUSER_WIDTH;
   localparam int KW = C_M_AXIS_DATA_WIDTH / 8;
   localparam int SW = DW + UW + KW + 1;

   function automatic logic [CREDIT_WIDTH-1:0] eff_weight(input logic [CREDIT_WIDTH-1:0] w);
      return (w == '0) ? CREDIT_WIDTH'(DEFAULT_WEIGHT) : w;
   endfunction

   state_t                  state_q, state_d;
   src_t                    ptr_q, ptr_d;
   logic [CREDIT_WIDTH-1:0] credit_q, credit_d;
   logic [CNT_WIDTH-1:0]    byp_cnt_q, byp_cnt_d;
   logic [CNT_WIDTH-1:0]    agg_cnt_q, agg_cnt_d;

   logic          slice_in_valid;
   logic          slice_in_ready;
   logic [SW-1:0] slice_in_data;
   logic [SW-1:0] slice_out_data;
   logic          byp_last_fire;
   logic          agg_last_fire;
   logic          p_valid;
   logic          o_valid;

   always_comb begin
      s_axis_byp_tready = (state_q == FWD_BYP) && slice_in_ready;
      s_axis_agg_tready = (state_q == FWD_AGG) && slice_in_ready;
      byp_last_fire     = s_axis_byp_tvalid && s_axis_byp_tready && s_axis_byp_tlast;
      agg_last_fire     = s_axis_agg_tvalid && s_axis_agg_tready && s_axis_agg_tlast;

      slice_in_valid = ((state_q == FWD_BYP) && s_axis_byp_tvalid) ||
                       ((state_q == FWD_AGG) && s_axis_agg_tvalid);
      slice_in_data  = (state_q == FWD_AGG) ?
                       {s_axis_agg_tlast, s_axis_agg_tkeep, s_axis_agg_tuser, s_axis_agg_tdata} :
                       {s_axis_byp_tlast, s_axis_byp_tkeep, s_axis_byp_tuser, s_axis_byp_tdata};
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      credit_d = credit_q;
      p_valid  = (ptr_q == SRC_BYP) ? s_axis_byp_tvalid : s_axis_agg_tvalid;
      o_valid  = (ptr_q == SRC_BYP) ? s_axis_agg_tvalid : s_axis_byp_tvalid;
      case (state_q)
         ARB: begin
            if (p_valid) begin
               state_d = (ptr_q == SRC_BYP) ? FWD_BYP : FWD_AGG;
            end else if (o_valid) begin
               // Idle pointer source hands the turn over immediately with a fresh credit.
               ptr_d    = other_src(ptr_q);
               state_d  = (ptr_d == SRC_BYP) ? FWD_BYP : FWD_AGG;
               credit_d = (ptr_d == SRC_BYP) ? eff_weight(cfg_weight_byp)
                                             : eff_weight(cfg_weight_agg);
            end
         end
         FWD_BYP, FWD_AGG: begin
            if ((state_q == FWD_BYP) ? byp_last_fire : agg_last_fire) begin
               state_d = ARB;
               if (credit_q <= CREDIT_WIDTH'(1)) begin
                  ptr_d    = other_src(ptr_q);
                  credit_d = (ptr_d == SRC_BYP) ? eff_weight(cfg_weight_byp)
                                                : eff_weight(cfg_weight_agg);
               end else begin
                  credit_d = credit_q - CREDIT_WIDTH'(1);
               end
            end
         end
         default: state_d = ARB;
      endcase
   end

   always_comb begin
      byp_cnt_d = byp_cnt_q;
      agg_cnt_d = agg_cnt_q;
      if (clear_counters) begin
         byp_cnt_d = '0;
         agg_cnt_d = '0;
      end else begin
         if (byp_last_fire) byp_cnt_d = byp_cnt_q + CNT_WIDTH'(1);
         if (agg_last_fire) agg_cnt_d = agg_cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge axis_aclk) begin
      if (axis_reset) begin
         state_q   <= ARB;
         ptr_q     <= SRC_BYP;
         credit_q  <= eff_weight(cfg_weight_byp);
         byp_cnt_q <= '0;
         agg_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         credit_q  <= credit_d;
         byp_cnt_q <= byp_cnt_d;
         agg_cnt_q <= agg_cnt_d;
      end
   end

   assign pkt_byp_cnt = byp_cnt_q;
   assign pkt_agg_cnt = agg_cnt_q;

   axis_skid_slice #(
      .WIDTH(SW)
   ) u_out_slice (
      .clk       (axis_aclk),
      .rst       (axis_reset),
      .in_valid  (slice_in_valid),
      .in_ready  (slice_in_ready),
      .in_data   (slice_in_data),
      .out_valid (m_axis_tvalid),
      .out_ready (m_axis_tready),
      .out_data  (slice_out_data)
   );

   assign {m_axis_tlast, m_axis_tkeep, m_axis_tuser, m_axis_tdata} = slice_out_data;

endmodule

// File: tb/tb_agg_oq_merge_arbiter.sv
// Directed bench for agg_oq_merge_arbiter: queue-driven sources, output monitor, per-feature tasks.
module tb_agg_oq_merge_arbiter;
   import agg_oq_merge_arbiter_pkg::*;

   localparam int DW = 64;
   localparam int UW = 128;
   localparam int KW = 8;

   typedef struct {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic [UW-1:0] user;
      logic          last;
      int            gap;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] s_tdata [2];
   logic [KW-1:0] s_tkeep [2];
   logic [UW-1:0] s_tuser [2];
   logic          s_tvalid [2] = '{1'b0, 1'b0};
   logic          s_tready [2];
   logic          s_tlast [2];
   logic [DW-1:0] m_tdata;
   logic [KW-1:0] m_tkeep;
   logic [UW-1:0] m_tuser;
   logic          m_tvalid;
   logic          m_tready = 1'b1;
   logic          m_tlast;
   logic [3:0]    cfg_w_byp = 4'd1;
   logic [3:0]    cfg_w_agg = 4'd1;
   logic          clear = 1'b0;
   logic [31:0]   cnt_byp;
   logic [31:0]   cnt_agg;

   int    vectors = 0;
   int    miscompares = 0;
   int    cyc = 0;
   bit    rand_ready = 1'b0;
   bit    fire_n [2];
   beat_t src_q [2][$];
   beat_t exp_q [2][$];
   beat_t out_q [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   agg_oq_merge_arbiter #(
      .C_M_AXIS_DATA_WIDTH (DW),
      .C_M_AXIS_TUSER_WIDTH(UW),
      .CREDIT_WIDTH        (4),
      .CNT_WIDTH           (32)
   ) dut (
      .axis_aclk        (clk),
      .axis_reset       (rst),
      .s_axis_byp_tdata (s_tdata[0]),
      .s_axis_byp_tkeep (s_tkeep[0]),
      .s_axis_byp_tuser (s_tuser[0]),
      .s_axis_byp_tvalid(s_tvalid[0]),
      .s_axis_byp_tready(s_tready[0]),
      .s_axis_byp_tlast (s_tlast[0]),
      .s_axis_agg_tdata (s_tdata[1]),
      .s_axis_agg_tkeep (s_tkeep[1]),
      .s_axis_agg_tuser (s_tuser[1]),
      .s_axis_agg_tvalid(s_tvalid[1]),
      .s_axis_agg_tready(s_tready[1]),
      .s_axis_agg_tlast (s_tlast[1]),
      .m_axis_tdata     (m_tdata),
      .m_axis_tkeep     (m_tkeep),
      .m_axis_tuser     (m_tuser),
      .m_axis_tvalid    (m_tvalid),
      .m_axis_tready    (m_tready),
      .m_axis_tlast     (m_tlast),
      .cfg_weight_byp   (cfg_w_byp),
      .cfg_weight_agg   (cfg_w_agg),
      .clear_counters   (clear),
      .pkt_byp_cnt      (cnt_byp),
      .pkt_agg_cnt      (cnt_agg)
   );

   // Handshakes and output beats are sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      beat_t o;
      for (int s = 0; s < 2; s++) fire_n[s] = s_tvalid[s] && s_tready[s];
      if (m_tvalid && m_tready) begin
         o.data = m_tdata; o.keep = m_tkeep; o.user = m_tuser; o.last = m_tlast; o.gap = cyc;
         out_q.push_back(o);
      end
   end

   task automatic drive_src(input int s);
      int waited = 0;
      forever begin
         @(posedge clk); #1;
         if (fire_n[s] && src_q[s].size() > 0) begin
            void'(src_q[s].pop_front());
            waited = 0;
         end
         if (src_q[s].size() == 0) begin
            waited = 0;
            s_tvalid[s] = 1'b0;
         end else if (waited < src_q[s][0].gap) begin
            waited++;
            s_tvalid[s] = 1'b0;
         end else begin
            s_tvalid[s] = 1'b1;
            s_tdata[s]  = src_q[s][0].data;
            s_tkeep[s]  = src_q[s][0].keep;
            s_tuser[s]  = src_q[s][0].user;
            s_tlast[s]  = src_q[s][0].last;
         end
      end
   endtask

   initial drive_src(0);
   initial drive_src(1);
   initial forever begin
      @(posedge clk); #1;
      m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic add_pkt(input int s, input int len, input int pid, input int gap_beat, input int gap_len);
      beat_t b;
      for (int i = 0; i < len; i++) begin
         b.data    = {8'(s), 16'(pid), 8'(i), $urandom};
         b.keep    = 8'($urandom_range(1, 255));
         b.user    = {$urandom, $urandom, $urandom, $urandom};
         b.user[0] = s[0];
         b.last    = (i == len - 1);
         b.gap     = (i == gap_beat) ? gap_len : 0;
         src_q[s].push_back(b);
         exp_q[s].push_back(b);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      clear = 1'b0;
      for (int s = 0; s < 2; s++) begin
         src_q[s].delete();
         exp_q[s].delete();
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      out_q.delete();
   endtask

   task automatic wait_beats(input int n, input int budget);
      int k = 0;
      while (out_q.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      vectors++;
      if (out_q.size() < n) begin
         miscompares++;
         $display("FAIL wait_beats: got %0d beats, required %0d within %0d cycles", out_q.size(), n, budget);
      end
   endtask

   task automatic wait_src_valid(input int s, output int n);
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!s_tvalid[s] && k < 20);
      n = cyc;
   endtask

   task automatic test_reset();
      do_reset();
      vectors++;
      if (m_tvalid !== 1'b0 || s_tready[0] !== 1'b0 || s_tready[1] !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_handshake: m_tvalid=%b tready=%b%b, required 0 00", m_tvalid, s_tready[0], s_tready[1]);
      end
      vectors++;
      if (cnt_byp !== 32'd0 || cnt_agg !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_counters: byp=%0d agg=%0d, required 0 0", cnt_byp, cnt_agg);
      end
      vectors++;
      if (dut.state_q !== ARB) begin
         miscompares++;
         $display("FAIL reset_state: got %0d, required ARB", dut.state_q);
      end
   endtask

   task automatic test_single_byp();
      int n;
      cfg_w_byp = 4'd1; cfg_w_agg = 4'd1;
      do_reset();
      add_pkt(0, 3, 1, -1, 0);
      wait_src_valid(0, n);
      wait_beats(3, 20);
      repeat (4) @(negedge clk);
      vectors++;
      if (out_q.size() != 3) begin
         miscompares++;
         $display("FAIL single_count: got %0d beats, required 3", out_q.size());
      end
      for (int i = 0; i < 3 && i < out_q.size(); i++) begin
         vectors++;
         if (out_q[i].gap != n + 2 + i || out_q[i].last !== (i == 2) || out_q[i].data !== exp_q[0][i].data ||
             out_q[i].keep !== exp_q[0][i].keep || out_q[i].user !== exp_q[0][i].user) begin
            miscompares++;
            $display("FAIL single_beat%0d: cycle=%0d last=%b data=%h, required cycle=%0d last=%b data=%h",
                     i, out_q[i].gap, out_q[i].last, out_q[i].data, n + 2 + i, (i == 2), exp_q[0][i].data);
         end
      end
      vectors++;
      if (cnt_byp !== 32'd1 || cnt_agg !== 32'd0) begin
         miscompares++;
         $display("FAIL single_cnt: byp=%0d agg=%0d, required 1 0", cnt_byp, cnt_agg);
      end
   endtask

   task automatic test_weighted();
      cfg_w_byp = 4'd2; cfg_w_agg = 4'd1;
      do_reset();
      for (int p = 0; p < 20; p++) add_pkt(0, 2, p, -1, 0);
      for (int p = 0; p < 10; p++) add_pkt(1, 2, p, -1, 0);
      wait_beats(60, 400);
      for (int p = 0; p < 30 && 2 * p + 1 < out_q.size(); p++) begin
         vectors++;
         if (out_q[2 * p].user[0] !== ((p % 3) == 2) || out_q[2 * p + 1].user[0] !== out_q[2 * p].user[0] ||
             out_q[2 * p].last !== 1'b0 || out_q[2 * p + 1].last !== 1'b1) begin
            miscompares++;
            $display("FAIL weighted_pkt%0d: src=%b last=%b%b, required src=%b last=01",
                     p, out_q[2 * p].user[0], out_q[2 * p].last, out_q[2 * p + 1].last, ((p % 3) == 2));
         end
      end
      repeat (2) @(negedge clk);
      vectors++;
      if (cnt_byp !== 32'd20 || cnt_agg !== 32'd10) begin
         miscompares++;
         $display("FAIL weighted_cnt: byp=%0d agg=%0d, required 20 10", cnt_byp, cnt_agg);
      end
   endtask

   task automatic test_random_ready();
      int total = 0;
      int npk [2] = '{0, 0};
      int cur = -1;
      cfg_w_byp = 4'd3; cfg_w_agg = 4'd2;
      do_reset();
      rand_ready = 1'b1;
      for (int p = 0; p < 100; p++) begin
         int s   = $urandom_range(0, 1);
         int len = $urandom_range(1, 5);
         add_pkt(s, len, p, -1, 0);
         total += len;
         npk[s]++;
      end
      wait_beats(total, 4000);
      rand_ready = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < out_q.size(); i++) begin
         beat_t o = out_q[i];
         beat_t e;
         int    s = int'(o.user[0]);
         vectors++;
         if (cur >= 0 && s != cur) begin
            miscompares++;
            $display("FAIL sb_interleave: beat %0d from src %0d, required src %0d", i, s, cur);
         end
         vectors++;
         if (exp_q[s].size() == 0) begin
            miscompares++;
            $display("FAIL sb_extra: beat %0d src %0d data=%h, required no beat", i, s, o.data);
         end else begin
            e = exp_q[s].pop_front();
            if (o.data !== e.data || o.keep !== e.keep || o.user !== e.user || o.last !== e.last) begin
               miscompares++;
               $display("FAIL sb_beat%0d: data=%h keep=%h last=%b, required data=%h keep=%h last=%b",
                        i, o.data, o.keep, o.last, e.data, e.keep, e.last);
            end
         end
         cur = o.last ? -1 : s;
      end
      vectors++;
      if (cnt_byp !== 32'(npk[0]) || cnt_agg !== 32'(npk[1])) begin
         miscompares++;
         $display("FAIL sb_cnt: byp=%0d agg=%0d, required %0d %0d", cnt_byp, cnt_agg, npk[0], npk[1]);
      end
   endtask

   task automatic test_mid_stall();
      int n;
      cfg_w_byp = 4'd1; cfg_w_agg = 4'd1;
      do_reset();
      add_pkt(1, 4, 0, 2, 5);
      wait_src_valid(1, n);
      @(negedge clk);
      add_pkt(0, 2, 1, -1, 0);
      add_pkt(0, 2, 2, -1, 0);
      wait_beats(8, 100);
      for (int i = 0; i < 8 && i < out_q.size(); i++) begin
         vectors++;
         if (out_q[i].user[0] !== (i < 4) || out_q[i].last !== (i == 3 || i == 5 || i == 7)) begin
            miscompares++;
            $display("FAIL stall_beat%0d: src=%b last=%b, required src=%b last=%b",
                     i, out_q[i].user[0], out_q[i].last, (i < 4), (i == 3 || i == 5 || i == 7));
         end
      end
      vectors++;
      if (out_q.size() >= 3 && out_q[2].gap - out_q[1].gap != 6) begin
         miscompares++;
         $display("FAIL stall_gap: beat spacing %0d cycles, required 6", out_q[2].gap - out_q[1].gap);
      end
   endtask

   task automatic test_weight_zero();
      cfg_w_byp = 4'd1; cfg_w_agg = 4'd0;
      do_reset();
      for (int p = 0; p < 10; p++) begin
         add_pkt(0, 1, p, -1, 0);
         add_pkt(1, 1, p, -1, 0);
      end
      wait_beats(20, 200);
      for (int i = 0; i < 20 && i < out_q.size(); i++) begin
         vectors++;
         if (out_q[i].user[0] !== i[0]) begin
            miscompares++;
            $display("FAIL wzero_pkt%0d: src=%b, required %b", i, out_q[i].user[0], i[0]);
         end
      end
   endtask

   task automatic test_clear_and_reset();
      int n;
      int k = 0;
      cfg_w_byp = 4'd1; cfg_w_agg = 4'd1;
      do_reset();
      add_pkt(0, 1, 0, -1, 0);
      wait_beats(1, 20);
      repeat (2) @(negedge clk);
      vectors++;
      if (cnt_byp !== 32'd1) begin
         miscompares++;
         $display("FAIL clr_pre: byp=%0d, required 1", cnt_byp);
      end
      add_pkt(0, 1, 1, -1, 0);
      wait_src_valid(0, n);
      @(negedge clk);
      vectors++;
      if (!(s_tvalid[0] && s_tready[0])) begin
         miscompares++;
         $display("FAIL clr_handshake: valid=%b ready=%b, required 1 1", s_tvalid[0], s_tready[0]);
      end
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      repeat (2) @(negedge clk);
      vectors++;
      if (cnt_byp !== 32'd0 || cnt_agg !== 32'd0) begin
         miscompares++;
         $display("FAIL clr_cnt: byp=%0d agg=%0d, required 0 0", cnt_byp, cnt_agg);
      end
      add_pkt(0, 6, 2, -1, 0);
      while (!m_tvalid && k < 20) begin
         @(negedge clk);
         k++;
      end
      vectors++;
      if (!m_tvalid) begin
         miscompares++;
         $display("FAIL rst_start: m_tvalid=%b, required 1", m_tvalid);
      end
      rst = 1'b1;
      src_q[0].delete();
      @(posedge clk); #1;
      vectors++;
      if (m_tvalid !== 1'b0 || dut.state_q !== ARB || s_tready[0] !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_mid: m_tvalid=%b state=%0d tready=%b, required 0 ARB 0", m_tvalid, dut.state_q, s_tready[0]);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_byp();
      test_weighted();
      test_random_ready();
      test_mid_stall();
      test_weight_zero();
      test_clear_and_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
